// File: rtl/avalon_st_seq_source.sv
// ---------------------------------------------------------------------------
// avalon_st_seq_source
//
// Avalon-ST source that emits packets of NUM_WORDS words forming an
// arithmetic sequence (BASE, BASE+STEP, ...), truncated to DATA_W bits.
// The source supports full ready/valid backpressure (ready latency 0) and
// SOP/EOP framing. It can send one packet per start pulse, or run
// continuously with IDLE_GAP idle cycles between packets.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   start          in   begins a packet; only looked at in IDLE, ignored
//                       in continuous mode
//   ready          in   sink ready
//   valid          out  data valid (high throughout SEND)
//   data           out  current word
//   startofpacket  out  high with word 0
//   endofpacket    out  high with word NUM_WORDS-1
//   busy           out  high in SEND or GAP
//   done           out  one-cycle pulse after the last transfer of a packet
//   pkt_count      out  completed packets, wraps at 16 bits
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module avalon_st_seq_source #(
    parameter int DATA_W     = 8,
    parameter int NUM_WORDS  = 3,
    parameter int BASE       = 4,
    parameter int STEP       = 1,
    parameter int CONTINUOUS = 0,
    parameter int IDLE_GAP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              startofpacket,
    output logic              endofpacket,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_count
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [DATA_W-1:0] BASE_W   = DATA_W'(BASE);
    localparam logic [DATA_W-1:0] STEP_W   = DATA_W'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              sop_q,   sop_d;
    logic              eop_q,   eop_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [15:0]       cnt_q,   cnt_d;

    logic xfer;
    logic pkt_end;

    // valid is high exactly while in SEND, so a transfer is SEND && ready.
    assign xfer    = (state_q == ST_SEND) && ready;
    assign pkt_end = xfer && (idx_q == LAST_IDX);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Continuous mode leaves IDLE on its own; start is ignored.
                if ((CONTINUOUS != 0) || start) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pkt_end) begin
                    if (CONTINUOUS == 0) begin
                        state_d = ST_IDLE;
                    end else if (IDLE_GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;

        if (pkt_end || (state_q != ST_SEND)) begin
            // Outside a packet, or finishing one: rewind to word 0. The data
            // register only loads BASE when a new packet is about to show.
            idx_d = '0;
            if (state_d == ST_SEND) begin
                data_d = BASE_W;
            end
        end else if (xfer) begin
            // Running sum instead of BASE + idx*STEP; wraps modulo 2^DATA_W.
            idx_d  = idx_q + 1'b1;
            data_d = data_q + STEP_W;
        end
        // Stalled in SEND (valid && !ready): everything above holds.

        gap_d   = ((state_q == ST_GAP) && (state_d == ST_GAP)) ? gap_q + 1'b1 : '0;

        valid_d = (state_d == ST_SEND);
        sop_d   = (state_d == ST_SEND) && (idx_d == '0);
        eop_d   = (state_d == ST_SEND) && (idx_d == LAST_IDX);
        busy_d  = (state_d != ST_IDLE);
        done_d  = pkt_end;
        cnt_d   = cnt_q + 16'(pkt_end);
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid         = valid_q;
    assign data          = data_q;
    assign startofpacket = sop_q;
    assign endofpacket   = eop_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_avalon_st_seq_source.sv
module tb_avalon_st_seq_source;

    // Instances: 0 = defaults, 1 = 4-bit wrap (5 words from 14),
    //            2 = single word, 3 = continuous gap 2, 4 = continuous gap 0
    logic        clk;
    logic        reset;
    logic [4:0]  start_v;
    logic [4:0]  ready_v;
    logic [4:0]  valid_v;
    logic [4:0]  sop_v;
    logic [4:0]  eop_v;
    logic [4:0]  busy_v;
    logic [4:0]  done_v;
    logic [7:0]  data_v [5];
    logic [15:0] pc_v   [5];
    logic [7:0]  d0, d2, d3, d4;
    logic [3:0]  d1;

    assign data_v[0] = d0;
    assign data_v[1] = {4'b0000, d1};
    assign data_v[2] = d2;
    assign data_v[3] = d3;
    assign data_v[4] = d4;

    avalon_st_seq_source u_def (
        .clk(clk), .reset(reset), .start(start_v[0]), .ready(ready_v[0]),
        .valid(valid_v[0]), .data(d0), .startofpacket(sop_v[0]), .endofpacket(eop_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pkt_count(pc_v[0]));

    avalon_st_seq_source #(.DATA_W(4), .NUM_WORDS(5), .BASE(14), .STEP(1)) u_wrap (
        .clk(clk), .reset(reset), .start(start_v[1]), .ready(ready_v[1]),
        .valid(valid_v[1]), .data(d1), .startofpacket(sop_v[1]), .endofpacket(eop_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pkt_count(pc_v[1]));

    avalon_st_seq_source #(.NUM_WORDS(1)) u_one (
        .clk(clk), .reset(reset), .start(start_v[2]), .ready(ready_v[2]),
        .valid(valid_v[2]), .data(d2), .startofpacket(sop_v[2]), .endofpacket(eop_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pkt_count(pc_v[2]));

    avalon_st_seq_source #(.CONTINUOUS(1), .IDLE_GAP(2)) u_gap2 (
        .clk(clk), .reset(reset), .start(start_v[3]), .ready(ready_v[3]),
        .valid(valid_v[3]), .data(d3), .startofpacket(sop_v[3]), .endofpacket(eop_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pkt_count(pc_v[3]));

    avalon_st_seq_source #(.CONTINUOUS(1), .IDLE_GAP(0)) u_gap0 (
        .clk(clk), .reset(reset), .start(start_v[4]), .ready(ready_v[4]),
        .valid(valid_v[4]), .data(d4), .startofpacket(sop_v[4]), .endofpacket(eop_v[4]),
        .busy(busy_v[4]), .done(done_v[4]), .pkt_count(pc_v[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t exp_q[$];
    int   sel;
    int   n_checks;
    int   n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_pkt(input int base, input int step, input int n, input int mask);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = 8'((base + i * step) & mask);
            e.sop  = (i == 0);
            e.eop  = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge with this cycle's inputs already driven: a transfer
    // will happen at the coming posedge if valid && ready.
    task automatic tick();
        if (valid_v[sel] && ready_v[sel]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("inst%0d_data", sel), 32'(data_v[sel]), 32'(e.data));
                check($sformatf("inst%0d_sop", sel), 32'(sop_v[sel]), 32'(e.sop));
                check($sformatf("inst%0d_eop", sel), 32'(eop_v[sel]), 32'(e.eop));
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 100) begin
            tick();
            cycles++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        int vseen;
        n_checks = 0;
        n_pass   = 0;
        sel      = 0;
        reset    = 1'b1;
        start_v  = '0;
        ready_v  = '0;
        @(negedge clk);

        // Reset values
        check("rst_valid", 32'(valid_v[0]), 32'd0);
        check("rst_data",  32'(data_v[0]),  32'd0);
        check("rst_sop",   32'(sop_v[0]),   32'd0);
        check("rst_eop",   32'(eop_v[0]),   32'd0);
        check("rst_busy",  32'(busy_v[0]),  32'd0);
        check("rst_done",  32'(done_v[0]),  32'd0);
        check("rst_pkt",   32'(pc_v[0]),    32'd0);
        check("rst_cont_valid", 32'(valid_v[3]), 32'd0);
        reset = 1'b0;

        // Default packet, no backpressure
        sel = 0;
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        push_pkt(4, 1, 3, 255);
        tick();
        start_v[0] = 1'b0;
        check("p1_latency_valid", 32'(valid_v[0]), 32'd1);
        check("p1_busy", 32'(busy_v[0]), 32'd1);
        drain(cyc);
        check("p1_cycles", 32'(cyc), 32'd3);
        check("p1_done", 32'(done_v[0]), 32'd1);
        check("p1_valid_after", 32'(valid_v[0]), 32'd0);
        check("p1_pkt", 32'(pc_v[0]), 32'd1);
        tick();
        check("p1_done_pulse", 32'(done_v[0]), 32'd0);
        check("p1_busy_idle", 32'(busy_v[0]), 32'd0);

        // Backpressure on word 5, start pulsed mid-packet
        start_v[0] = 1'b1;
        push_pkt(4, 1, 3, 255);
        tick();
        start_v[0] = 1'b0;
        tick();
        ready_v[0] = 1'b0;
        start_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start_v[0] = 1'b0;
            check($sformatf("bp_valid_%0d", i), 32'(valid_v[0]), 32'd1);
            check($sformatf("bp_data_%0d", i), 32'(data_v[0]), 32'd5);
        end
        ready_v[0] = 1'b1;
        drain(cyc);
        check("bp_cycles", 32'(cyc), 32'd2);
        check("bp_done", 32'(done_v[0]), 32'd1);
        check("bp_pkt", 32'(pc_v[0]), 32'd2);
        vseen = 0;
        for (int i = 0; i < 4; i++) begin
            vseen = vseen | int'(valid_v[0]);
            tick();
        end
        check("busy_start_ignored", 32'(vseen), 32'd0);

        // start coincident with done
        start_v[0] = 1'b1;
        push_pkt(4, 1, 3, 255);
        tick();
        start_v[0] = 1'b0;
        drain(cyc);
        check("sd_done", 32'(done_v[0]), 32'd1);
        start_v[0] = 1'b1;
        push_pkt(4, 1, 3, 255);
        tick();
        start_v[0] = 1'b0;
        check("sd_valid", 32'(valid_v[0]), 32'd1);
        drain(cyc);
        check("sd_pkt", 32'(pc_v[0]), 32'd4);

        // 4-bit data wrap
        sel = 1;
        ready_v[1] = 1'b1;
        start_v[1] = 1'b1;
        push_pkt(14, 1, 5, 15);
        tick();
        start_v[1] = 1'b0;
        drain(cyc);
        check("wrap_cycles", 32'(cyc), 32'd5);
        check("wrap_pkt", 32'(pc_v[1]), 32'd1);

        // Single-word packet
        sel = 2;
        ready_v[2] = 1'b1;
        start_v[2] = 1'b1;
        push_pkt(4, 1, 1, 255);
        tick();
        start_v[2] = 1'b0;
        drain(cyc);
        check("one_cycles", 32'(cyc), 32'd1);
        check("one_done", 32'(done_v[2]), 32'd1);
        check("one_pkt", 32'(pc_v[2]), 32'd1);

        // Continuous, gap 2 (stalled since reset with ready low)
        sel = 3;
        check("g2_stall_valid", 32'(valid_v[3]), 32'd1);
        check("g2_stall_data", 32'(data_v[3]), 32'd4);
        ready_v[3] = 1'b1;
        push_pkt(4, 1, 3, 255);
        drain(cyc);
        check("g2_cycles", 32'(cyc), 32'd3);
        check("g2_gap0_valid", 32'(valid_v[3]), 32'd0);
        check("g2_done", 32'(done_v[3]), 32'd1);
        check("g2_pkt1", 32'(pc_v[3]), 32'd1);
        tick();
        check("g2_gap1_valid", 32'(valid_v[3]), 32'd0);
        check("g2_gap1_busy", 32'(busy_v[3]), 32'd1);
        tick();
        check("g2_restart_valid", 32'(valid_v[3]), 32'd1);
        push_pkt(4, 1, 3, 255);
        drain(cyc);
        check("g2_cycles2", 32'(cyc), 32'd3);
        check("g2_pkt2", 32'(pc_v[3]), 32'd2);
        ready_v[3] = 1'b0;

        // Continuous, no gap
        sel = 4;
        ready_v[4] = 1'b1;
        push_pkt(4, 1, 3, 255);
        push_pkt(4, 1, 3, 255);
        drain(cyc);
        check("g0_cycles", 32'(cyc), 32'd6);
        check("g0_pkt", 32'(pc_v[4]), 32'd2);
        check("g0_next_valid", 32'(valid_v[4]), 32'd1);
        check("g0_next_sop", 32'(sop_v[4]), 32'd1);
        ready_v[4] = 1'b0;

        // Reset mid-packet
        sel = 0;
        start_v[0] = 1'b1;
        push_pkt(4, 1, 3, 255);
        tick();
        start_v[0] = 1'b0;
        tick();
        check("mr_data5", 32'(data_v[0]), 32'd5);
        ready_v[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("mr_valid", 32'(valid_v[0]), 32'd0);
        check("mr_data",  32'(data_v[0]),  32'd0);
        check("mr_sop",   32'(sop_v[0]),   32'd0);
        check("mr_eop",   32'(eop_v[0]),   32'd0);
        check("mr_busy",  32'(busy_v[0]),  32'd0);
        check("mr_done",  32'(done_v[0]),  32'd0);
        check("mr_pkt",   32'(pc_v[0]),    32'd0);
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        push_pkt(4, 1, 3, 255);
        tick();
        start_v[0] = 1'b0;
        drain(cyc);
        check("mr_fresh_cycles", 32'(cyc), 32'd3);
        check("mr_fresh_pkt", 32'(pc_v[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
